// File: rtl/sseg_scan_decoder_pkg.sv
// Shared definitions for the 7-segment scan decoder: glyph patterns (a..g, active-low),
// FSM state encoding and the anode strobe classifier.
package sseg_scan_decoder_pkg;

    localparam logic [6:0] SSEG_0     = 7'b0000001;
    localparam logic [6:0] SSEG_1     = 7'b1001111;
    localparam logic [6:0] SSEG_2     = 7'b0010010;
    localparam logic [6:0] SSEG_3     = 7'b0000110;
    localparam logic [6:0] SSEG_4     = 7'b1001100;
    localparam logic [6:0] SSEG_5     = 7'b0100100;
    localparam logic [6:0] SSEG_6     = 7'b0100000;
    localparam logic [6:0] SSEG_7     = 7'b0001111;
    localparam logic [6:0] SSEG_8     = 7'b0000000;
    localparam logic [6:0] SSEG_9     = 7'b0000100;
    localparam logic [6:0] SSEG_A     = 7'b0001000;
    localparam logic [6:0] SSEG_B     = 7'b1100000;
    localparam logic [6:0] SSEG_C     = 7'b0110001;
    localparam logic [6:0] SSEG_D     = 7'b1000010;
    localparam logic [6:0] SSEG_E     = 7'b0110000;
    localparam logic [6:0] SSEG_F     = 7'b0111000;
    localparam logic [6:0] SSEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [1:0] idx;
    } strobe_t;

    // Exactly one low anode is a legal strobe; blank and ghost patterns are both illegal.
    function automatic strobe_t strobe_decode(input logic [3:0] an);
        strobe_t s;
        s.legal = 1'b1;
        s.idx   = 2'd0;
        case (an)
            4'b1110: s.idx = 2'd0;
            4'b1101: s.idx = 2'd1;
            4'b1011: s.idx = 2'd2;
            4'b0111: s.idx = 2'd3;
            default: s.legal = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sseg_scan_decoder_if.sv
// Display bus plus readback results; master drives the scanned bus, slave is the decoder.
interface sseg_scan_decoder_if;
    logic [0:6]  SSeg_in;
    logic [3:0]  an_in;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        capture;
    logic        pattern_err;
    logic [1:0]  err_digit;

    modport master (
        output SSeg_in, an_in,
        input  digits, digit_valid, frame_valid, capture, pattern_err, err_digit
    );

    modport slave (
        input  SSeg_in, an_in,
        output digits, digit_valid, frame_valid, capture, pattern_err, err_digit
    );
endinterface

// File: rtl/sseg_scan_decoder_glyph_decode.sv
// Inverse hex glyph lookup: 7-bit active-low pattern to {hit, nibble}.
module sseg_scan_decoder_glyph_decode
    import sseg_scan_decoder_pkg::*;
(
    input  logic [0:6] seg,
    output logic       hit,
    output logic [3:0] nibble
);

    always_comb begin
        hit    = 1'b1;
        nibble = 4'h0;
        case (seg)
            SSEG_0:  nibble = 4'h0;
            SSEG_1:  nibble = 4'h1;
            SSEG_2:  nibble = 4'h2;
            SSEG_3:  nibble = 4'h3;
            SSEG_4:  nibble = 4'h4;
            SSEG_5:  nibble = 4'h5;
            SSEG_6:  nibble = 4'h6;
            SSEG_7:  nibble = 4'h7;
            SSEG_8:  nibble = 4'h8;
            SSEG_9:  nibble = 4'h9;
            SSEG_A:  nibble = 4'hA;
            SSEG_B:  nibble = 4'hB;
            SSEG_C:  nibble = 4'hC;
            SSEG_D:  nibble = 4'hD;
            SSEG_E:  nibble = 4'hE;
            SSEG_F:  nibble = 4'hF;
            default: hit    = 1'b0;
        endcase
    end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Receive side of a 4-digit multiplexed 7-segment bus: synchronise, wait for each strobe
// to settle, then inverse-decode one hex nibble per digit.
module sseg_scan_decoder
    import sseg_scan_decoder_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    sseg_scan_decoder_if.slave   bus
);

    localparam int             TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]     STAB_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0]  TO_MAX    = TW'(TIMEOUT_CYCLES);

    logic [0:6]    seg_s1_reg, seg_s2_reg, seg_samp_reg, seg_prev_reg;
    logic [3:0]    an_s1_reg, an_s2_reg, an_samp_reg, an_prev_reg;

    state_t        state_reg, state_next;
    logic [7:0]    stab_reg, stab_next;
    logic [TW-1:0] to_cnt_reg;

    logic [3:0]    digit_reg [4];
    logic [3:0]    digit_valid_reg;
    logic          capture_reg;
    logic          pattern_err_reg;
    logic [1:0]    err_digit_reg;

    logic          cap_fire;
    logic          changed;
    strobe_t       samp_strobe;
    logic          glyph_hit;
    logic [3:0]    glyph_nibble;

    assign changed     = (seg_samp_reg != seg_prev_reg) || (an_samp_reg != an_prev_reg);
    assign samp_strobe = strobe_decode(an_samp_reg);

    sseg_scan_decoder_glyph_decode u_glyph (
        .seg    (seg_samp_reg),
        .hit    (glyph_hit),
        .nibble (glyph_nibble)
    );

    always_comb begin
        state_next = state_reg;
        stab_next  = stab_reg;
        cap_fire   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (samp_strobe.legal) begin
                    state_next = ST_SETTLE;
                    stab_next  = 8'd0;
                end
            end
            ST_SETTLE: begin
                if (changed) begin
                    stab_next = 8'd0;
                    if (!samp_strobe.legal) state_next = ST_IDLE;
                end else if (stab_reg >= STAB_LAST) begin
                    cap_fire   = 1'b1;
                    state_next = ST_HELD;
                    stab_next  = 8'd0;
                end else begin
                    stab_next = stab_reg + 8'd1;
                end
            end
            ST_HELD: begin
                // One capture per settled strobe: only a change re-arms the FSM.
                if (changed) begin
                    stab_next  = 8'd0;
                    state_next = samp_strobe.legal ? ST_SETTLE : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                stab_next  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1_reg      <= '1;
            seg_s2_reg      <= '1;
            seg_samp_reg    <= '1;
            seg_prev_reg    <= '1;
            an_s1_reg       <= '1;
            an_s2_reg       <= '1;
            an_samp_reg     <= '1;
            an_prev_reg     <= '1;
            state_reg       <= ST_IDLE;
            stab_reg        <= 8'd0;
            to_cnt_reg      <= '0;
            for (int i = 0; i < 4; i++) digit_reg[i] <= 4'h0;
            digit_valid_reg <= 4'h0;
            capture_reg     <= 1'b0;
            pattern_err_reg <= 1'b0;
            err_digit_reg   <= 2'd0;
        end else begin
            seg_s1_reg      <= bus.SSeg_in;
            seg_s2_reg      <= seg_s1_reg;
            seg_samp_reg    <= seg_s2_reg;
            seg_prev_reg    <= seg_samp_reg;
            an_s1_reg       <= bus.an_in;
            an_s2_reg       <= an_s1_reg;
            an_samp_reg     <= an_s2_reg;
            an_prev_reg     <= an_samp_reg;
            state_reg       <= state_next;
            stab_reg        <= stab_next;
            capture_reg     <= cap_fire;
            pattern_err_reg <= cap_fire && !glyph_hit;
            if (cap_fire) begin
                to_cnt_reg <= '0;
                if (glyph_hit) begin
                    digit_reg[samp_strobe.idx]       <= glyph_nibble;
                    digit_valid_reg[samp_strobe.idx] <= 1'b1;
                end else begin
                    digit_valid_reg[samp_strobe.idx] <= 1'b0;
                    err_digit_reg                    <= samp_strobe.idx;
                end
            end else begin
                // Saturated counter means the display went quiet: keep nibbles, drop validity.
                if (to_cnt_reg != TO_MAX) to_cnt_reg <= to_cnt_reg + 1'b1;
                else                      digit_valid_reg <= 4'h0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit_out
            assign bus.digits[4*gi +: 4] = digit_reg[gi];
        end
    endgenerate

    assign bus.digit_valid = digit_valid_reg;
    assign bus.frame_valid = &digit_valid_reg;
    assign bus.capture     = capture_reg;
    assign bus.pattern_err = pattern_err_reg;
    assign bus.err_digit   = err_digit_reg;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Scoreboard bench for sseg_scan_decoder: stimulus queues expected captures, a negedge
// monitor pops and checks them whenever the capture pulse appears.
module tb_sseg_scan_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sseg_scan_decoder_if bus ();

    sseg_scan_decoder #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0] idx;
        logic       hit;
        logic [3:0] nib;
    } exp_t;

    logic [6:0] glyph [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int         checks    = 0;
    int         failures  = 0;
    int         cap_count = 0;
    exp_t       exp_q [$];
    logic [3:0] model_dig [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [1:0] idx, input logic hit, input logic [3:0] nib);
        exp_t e;
        if (hit) model_dig[idx] = nib;
        e.idx = idx;
        e.hit = hit;
        e.nib = hit ? nib : model_dig[idx];
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int cycles);
        bus.an_in   = an;
        bus.SSeg_in = seg;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_digits"},      32'(bus.digits),      32'h0);
        chk({tag, "_digit_valid"}, 32'(bus.digit_valid), 32'h0);
        chk({tag, "_frame_valid"}, 32'(bus.frame_valid), 32'h0);
        chk({tag, "_capture"},     32'(bus.capture),     32'h0);
        chk({tag, "_pattern_err"}, 32'(bus.pattern_err), 32'h0);
        chk({tag, "_err_digit"},   32'(bus.err_digit),   32'h0);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.capture) begin
            cap_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_capture actual=capture required=none digits=%h", bus.digits);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("capture idx=%0d hit=%0d nib=%h digits=%h valid=%b perr=%0d",
                         e.idx, e.hit, e.nib, bus.digits, bus.digit_valid, bus.pattern_err);
                chk("cap_nibble", 32'(bus.digits[4*e.idx +: 4]), 32'(e.nib));
                chk("cap_valid_bit", 32'(bus.digit_valid[e.idx]), 32'(e.hit));
                chk("cap_pattern_err", 32'(bus.pattern_err), 32'(!e.hit));
                if (!e.hit) chk("cap_err_digit", 32'(bus.err_digit), 32'(e.idx));
            end
        end
    end

    initial begin
        int c0;
        int n;
        bus.SSeg_in = '1;
        bus.an_in   = '1;
        for (int i = 0; i < 4; i++) model_dig[i] = 4'h0;

        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;

        // 1: scan digits 0..3 with glyphs 1..4
        push_exp(2'd0, 1'b1, 4'h1); drive(4'b1110, glyph[1], 10);
        push_exp(2'd1, 1'b1, 4'h2); drive(4'b1101, glyph[2], 10);
        push_exp(2'd2, 1'b1, 4'h3); drive(4'b1011, glyph[3], 10);
        push_exp(2'd3, 1'b1, 4'h4); drive(4'b0111, glyph[4], 10);
        chk("t1_digits",      32'(bus.digits),      32'h4321);
        chk("t1_digit_valid", 32'(bus.digit_valid), 32'hF);
        chk("t1_frame_valid", 32'(bus.frame_valid), 32'h1);
        chk("t1_captures",    32'(cap_count),       32'd4);

        // 2: every glyph on digit 0
        for (int i = 0; i < 16; i++) begin
            push_exp(2'd0, 1'b1, 4'(i));
            drive(4'b1110, glyph[i], 10);
        end
        chk("t2_digit0",   32'(bus.digits[3:0]), 32'hF);
        chk("t2_captures", 32'(cap_count),       32'd20);

        // 3: illegal pattern on digit 2
        push_exp(2'd2, 1'b0, 4'h0);
        drive(4'b1011, 7'b1111110, 10);
        chk("t3_digit_valid", 32'(bus.digit_valid), 32'hB);
        chk("t3_digit2_kept", 32'(bus.digits[11:8]), 32'h3);
        chk("t3_err_digit",   32'(bus.err_digit),   32'd2);

        // 4: unsettled toggling, then a 9-cycle hold
        c0 = cap_count;
        for (int k = 0; k < 8; k++) drive(4'b1101, (k % 2 == 1) ? glyph[5] : glyph[6], 3);
        chk("t4_no_capture", 32'(cap_count), 32'(c0));
        push_exp(2'd1, 1'b1, 4'h7);
        drive(4'b1101, glyph[7], 9);
        chk("t4_one_capture", 32'(cap_count), 32'(c0 + 1));

        // 5: ghost strobe, then silence past the timeout
        c0 = cap_count;
        drive(4'b1100, glyph[8], 20);
        chk("t5_ghost_no_capture", 32'(cap_count),       32'(c0));
        chk("t5_valid_before_to",  32'(bus.digit_valid), 32'hB);
        drive(4'b1111, 7'b1111111, 80);
        chk("t5_valid_after_to",   32'(bus.digit_valid), 32'h0);
        chk("t5_frame_after_to",   32'(bus.frame_valid), 32'h0);
        chk("t5_digits_kept",      32'(bus.digits),      32'h437F);

        // 6: reset in the middle of settling, then full-latency capture
        c0 = cap_count;
        drive(4'b0111, glyph[9], 6);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset("t6_mid_reset");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) model_dig[i] = 4'h0;
        chk("t6_no_capture_reset", 32'(cap_count), 32'(c0));
        drive(4'b1111, 7'b1111111, 6);
        push_exp(2'd3, 1'b1, 4'h9);
        bus.an_in   = 4'b0111;
        bus.SSeg_in = glyph[9];
        n = 0;
        while (!bus.capture && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_latency", 32'(n), 32'd8);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_digits",      32'(bus.digits),      32'h9000);
        chk("t6_digit_valid", 32'(bus.digit_valid), 32'h8);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
